// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and line-level constants shared by the UART transmitter and receiver.
//   state_t    : frame state machine states (PARITY only used when the
//                UART_TX_PARITY_EN build option is defined)
//   START_BIT  : line level of the start bit
//   STOP_BIT   : line level of the stop bit
//   IDLE_LEVEL : line level between frames
//   DATA_BITS  : data bits per frame
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; holding clear keeps
// the count at 0 so the first bit period starts cleanly after it is released.
// Ports:
//   clk           in  system clock, rising edge
//   clear         in  force the count to 0 on the next edge
//   bit_done      out current cycle is the last of a bit period
//   bit_done_next out the next cycle will be the last of a bit period; lets a
//                     client register a pulse that lines up with bit_done
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic clear,
  output logic bit_done,
  output logic bit_done_next
);

  localparam int W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + W'(1);
    if (clear || (cnt == LAST)) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    cnt <= cnt_next;
  end

  assign bit_done      = (cnt == LAST);
  assign bit_done_next = (cnt_next == LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, 8 data bits LSB first, optional even parity
// bit, stop bit. One-cycle acknowledge during the final stop-bit cycle.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (default 8N1).
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset (drops any frame, no ack)
//   tx_start     in   send request, honoured only while idle
//   data_o       in   byte to send, captured with the accepted request
//   txd          out  serial line, idle high
//   tx_busy      out  frame in progress
//   transmit_ack out  one-cycle pulse in the last stop-bit cycle
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_o,
  output logic       txd,
  output logic       tx_busy,
  output logic       transmit_ack
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       bit_done;
  logic       bit_done_next;
  logic       baud_clear;

`ifdef UART_TX_PARITY_EN
  logic       parity_bit;
`endif

  // The timer is held at zero while idle so the start bit gets a full period.
  assign baud_clear = rst || (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk           (clk),
    .clear         (baud_clear),
    .bit_done      (bit_done),
    .bit_done_next (bit_done_next)
  );

  // Each branch registers the line level for the following cycle, so txd
  // changes on the same edge as the state. The ack is set one edge early using
  // bit_done_next so that it coincides with the last stop-bit cycle, which for
  // a one-clock bit period is the very first STOP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      txd          <= IDLE_LEVEL;
      tx_busy      <= 1'b0;
      transmit_ack <= 1'b0;
      bit_cnt      <= 3'd0;
      shift        <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      transmit_ack <= 1'b0;
      case (state)
        IDLE: begin
          txd     <= IDLE_LEVEL;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shift   <= data_o;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data_o;
`endif
            state   <= START;
            txd     <= START_BIT;
            tx_busy <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
            txd     <= shift[0];
            shift   <= {1'b0, shift[7:1]};
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_bit;
`else
              state        <= STOP;
              txd          <= STOP_BIT;
              transmit_ack <= bit_done_next;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              txd     <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end
        end

        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (bit_done) begin
            state        <= STOP;
            txd          <= STOP_BIT;
            transmit_ack <= bit_done_next;
          end
`else
          state   <= IDLE;
          txd     <= IDLE_LEVEL;
          tx_busy <= 1'b0;
`endif
        end

        STOP: begin
          if (bit_done) begin
            state   <= IDLE;
            txd     <= IDLE_LEVEL;
            tx_busy <= 1'b0;
          end else begin
            transmit_ack <= bit_done_next;
          end
        end

        default: begin
          state   <= IDLE;
          txd     <= IDLE_LEVEL;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter; the transmit direction of the FPGA–ESP32/PC serial link and the counterpart of the uart_rx receiver.
- Accepts a byte through a single-cycle request and serialises it on txd: start bit, 8 data bits LSB first, stop bit.
- Issues a one-cycle acknowledge when the stop bit completes.
- Sits between the user/loopback logic and the txd pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); minimum legal value 1, which gives one bit per clk as in the rx bench timing.
DATA_BITS, 8, data bits per frame; fixed at 8, carried as a parameter for documentation only.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
tx_start  input  1  send request, sampled every cycle.
data_o  input  8  byte to transmit; sampled only in the cycle tx_start is accepted.
txd  output  1  serial line, idle high.
tx_busy  output  1  high while a frame is in progress.
transmit_ack  output  1  one-cycle pulse when the stop bit ends.

Behaviour:
- Reset: on rst high at a clk edge, the next cycle has txd=1, tx_busy=0, transmit_ack=0, state IDLE, bit and baud counters 0, shift register 0. This applies in any state, including mid-frame; the aborted frame is dropped with no ack.
- All outputs are registered; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: txd=1. When tx_start=1, latch data_o into the shift register and go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit. After bit 7, go to PARITY (feature on) or STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. In the last cycle, assert transmit_ack for that one cycle and return to IDLE.
- Latency: tx_start accepted at edge N → txd=0 from cycle N+1.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
- tx_busy: high from N+1 until the cycle after transmit_ack; low in IDLE.
- Requests while busy: tx_start is ignored in all non-IDLE states, with no queuing. data_o changes during a frame have no effect.
- Back-to-back: tx_start held high at the IDLE edge following ack starts the next frame. The minimum gap between frames is one idle cycle of txd=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. With CLKS_PER_BIT=1 the counter is constant 0 and each state lasts exactly one cycle. Counter width is $clog2(CLKS_PER_BIT+1).
- Bit counter: 3 bits, 0..7, cleared on entry to DATA.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and drives txd = even parity (XOR of the latched 8 bits) for CLKS_PER_BIT cycles before STOP. Frame is 8E1, 11 bits.
- Undefined: no PARITY state; frame is 8N1, 10 bits.
- Port list is identical in both builds.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, DATA_BITS=8.
  - Shared with uart_rx.
- One natural sub-module: uart_baud_gen. It takes CLKS_PER_BIT, a clear input and a bit_done output, and is reusable by the receiver. The FSM and shift register stay in uart_tx.

Test Plan:
- Reset then idle 20 cycles → txd=1, tx_busy=0, transmit_ack=0 throughout.
- CLKS_PER_BIT=1, data_o=0x9C, tx_start one cycle → txd per cycle 0,0,0,1,1,1,0,0,1,1. transmit_ack is high on the 10th frame cycle only; tx_busy is high for 10 cycles.
- CLKS_PER_BIT=4, data_o=0xA5 → each bit lasts 4 cycles and the line reads 0,1,0,1,0,0,1,0,1,1. With UART_TX_PARITY_EN, a parity bit 0 is inserted before stop, giving 44 cycles.
- tx_start pulsed again mid-frame with data_o=0xFF → ignored; the original 0x9C frame is unchanged and there is a single ack.
- tx_start held high, data_o=0x55 then 0x3C → two consecutive frames with one idle cycle between and two acks.
- rst asserted during DATA bit 3 → txd=1 on the next cycle, no ack, tx_busy=0. A new request afterwards sends a full correct frame.
